dual_clcg_stream: RTL and testbench



---
 rtl/dclcg_pkg.sv | 31 +++
 rtl/dual_clcg_stream_cs3a_lcg_step.sv | 25 ++
 rtl/dual_clcg_stream.sv | 142 ++++++++++++++
 tb/tb_dual_clcg_stream.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dclcg_pkg.sv
// Shared types and default constants for the parametrised modified dual-CLCG stream.
// Also provides lcg_next_ref, a plain-arithmetic reference step for test models.
package dclcg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FAIL
  } state_t;

  localparam int unsigned DEF_W         = 16;
  localparam int unsigned DEF_R1        = 1;
  localparam int unsigned DEF_R2        = 2;
  localparam int unsigned DEF_R3        = 1;
  localparam int unsigned DEF_R4        = 2;
  localparam int unsigned DEF_B1        = 1;
  localparam int unsigned DEF_B2        = 3;
  localparam int unsigned DEF_B3        = 5;
  localparam int unsigned DEF_B4        = 7;
  localparam int unsigned DEF_OUT_W     = 8;
  localparam int unsigned DEF_REP_LIMIT = 32;

  // s' = (s*(2^r+1) + b) mod 2^w, written without any carry-save structure.
  function automatic logic [31:0] lcg_next_ref(input logic [31:0] s, input int unsigned r,
                                               input int unsigned b, input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((s << r) + s + b) & mask;
  endfunction

endpackage

// File: rtl/dual_clcg_stream_cs3a_lcg_step.sv
// One LCG step s' = (s<<R)+s+B mod 2^W via a 3:2 carry-save compressor
// followed by a single carry-propagate add; carries past bit W-1 wrap away.
module cs3a_lcg_step #(
  parameter int unsigned W = 16,
  parameter int unsigned R = 1,
  parameter int unsigned B = 1
) (
  input  logic [W-1:0] s,
  output logic [W-1:0] s_next
);

  logic [W-1:0] op_a;
  logic [W-1:0] op_c;
  logic [W-1:0] sum;
  logic [W-1:0] carry;

  always_comb begin
    op_a   = s << R;
    op_c   = W'(B);
    sum    = op_a ^ s ^ op_c;
    carry  = ((op_a & s) | (op_a & op_c) | (s & op_c)) << 1;
    s_next = sum + carry;
  end

endmodule

// File: rtl/dual_clcg_stream.sv
// Modified dual-CLCG bit generator with word packer and valid/ready output.
// Optional repetition-count health test enabled by defining DCLCG_HEALTH_EN.
module dual_clcg_stream
  import dclcg_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned R1        = DEF_R1,
  parameter int unsigned R2        = DEF_R2,
  parameter int unsigned R3        = DEF_R3,
  parameter int unsigned R4        = DEF_R4,
  parameter int unsigned B1        = DEF_B1,
  parameter int unsigned B2        = DEF_B2,
  parameter int unsigned B3        = DEF_B3,
  parameter int unsigned B4        = DEF_B4,
  parameter int unsigned OUT_W     = DEF_OUT_W,
  parameter int unsigned REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_valid,
  output logic             seed_ready,
  input  logic [W-1:0]     x0,
  input  logic [W-1:0]     y0,
  input  logic [W-1:0]     p0,
  input  logic [W-1:0]     q0,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             health_fail
);

  localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned LAST  = OUT_W - 1;

  if (OUT_W < 1 || OUT_W > 32 || REP_LIMIT < 1) begin : g_bad_cfg
    $error("dual_clcg_stream: OUT_W must be 1..32 and REP_LIMIT at least 1");
  end

  state_t           state;
  logic [W-1:0]     x, p, y, q;
  logic [W-1:0]     xn, pn, yn, qn;
  logic [OUT_W-1:0] shreg;
  logic [OUT_W-1:0] word_next;
  logic [CNT_W-1:0] cnt;
  logic             bi, ci, emit, full_next, step, fail_now;

  cs3a_lcg_step #(.W(W), .R(R1), .B(B1)) u_step_x (.s(x), .s_next(xn));
  cs3a_lcg_step #(.W(W), .R(R2), .B(B2)) u_step_p (.s(p), .s_next(pn));
  cs3a_lcg_step #(.W(W), .R(R3), .B(B3)) u_step_y (.s(y), .s_next(yn));
  cs3a_lcg_step #(.W(W), .R(R4), .B(B4)) u_step_q (.s(q), .s_next(qn));

  assign seed_ready = 1'b1;

  // The bit rule looks at the post-step values, so the stall decision must too.
  always_comb begin
    bi        = (xn > pn);
    ci        = (yn > qn);
    emit      = !bi;
    full_next = emit && (cnt == CNT_W'(LAST));
    step      = (state == RUN) && en && !(dout_valid && !dout_ready && full_next);
    word_next = (shreg << 1) | OUT_W'(ci);
  end

`ifdef DCLCG_HEALTH_EN
  logic [31:0] rep_cnt;
  logic [31:0] rep_next;
  logic        last_bit;
  logic        rep_hit;

  always_comb begin
    rep_next = (rep_cnt != '0 && ci == last_bit) ? rep_cnt + 32'd1 : 32'd1;
    rep_hit  = (rep_next >= REP_LIMIT);
    fail_now = step && emit && rep_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      last_bit    <= 1'b0;
      health_fail <= 1'b0;
    end else if (seed_valid) begin
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else if (step && emit) begin
      rep_cnt  <= rep_next;
      last_bit <= ci;
      if (rep_hit) health_fail <= 1'b1;
    end
  end
`else
  assign fail_now    = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      p          <= '0;
      y          <= '0;
      q          <= '0;
      shreg      <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (seed_valid) begin
      state      <= RUN;
      x          <= x0;
      p          <= p0;
      y          <= y0;
      q          <= q0;
      shreg      <= '0;
      cnt        <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (dout_valid && dout_ready) dout_valid <= 1'b0;
      if (step) begin
        x <= xn;
        p <= pn;
        y <= yn;
        q <= qn;
        if (emit) begin
          // Stale high bits of shreg are shifted out before the next word completes.
          shreg <= word_next;
          if (cnt == CNT_W'(LAST)) begin
            cnt        <= '0;
            dout       <= word_next;
            dout_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
      if (fail_now) begin
        state      <= FAIL;
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dual_clcg_stream.sv
// Directed bench for dual_clcg_stream at W=4 with OUT_W=1 and OUT_W=2 instances.
module tb_dual_clcg_stream;
  import dclcg_pkg::*;

  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          seed_valid = 1'b0;
  logic          dout_ready = 1'b1;
  logic [TW-1:0] x0 = 4'd1, y0 = 4'd2, p0 = 4'd3, q0 = 4'd4;

  logic          sr1, v1, hf1, sr2, v2, hf2;
  logic [0:0]    dout1;
  logic [1:0]    dout2;

  int unsigned   n_cmp = 0;
  int unsigned   n_bad = 0;

  always #5 clk = ~clk;

  dual_clcg_stream #(.W(TW), .OUT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_valid(seed_valid), .seed_ready(sr1),
    .x0(x0), .y0(y0), .p0(p0), .q0(q0), .dout(dout1), .dout_valid(v1),
    .dout_ready(dout_ready), .health_fail(hf1)
  );

  dual_clcg_stream #(.W(TW), .OUT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_valid(seed_valid), .seed_ready(sr2),
    .x0(x0), .y0(y0), .p0(p0), .q0(q0), .dout(dout2), .dout_valid(v2),
    .dout_ready(dout_ready), .health_fail(hf2)
  );

`ifdef DCLCG_HEALTH_EN
  logic       sr3, v3, hf3;
  logic [0:0] dout3;

  dual_clcg_stream #(.W(TW), .OUT_W(1), .REP_LIMIT(2)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .seed_valid(seed_valid), .seed_ready(sr3),
    .x0(x0), .y0(y0), .p0(p0), .q0(q0), .dout(dout3), .dout_valid(v3),
    .dout_ready(dout_ready), .health_fail(hf3)
  );
`endif

  typedef struct {
    logic       sv, en, rdy;
    logic [3:0] ex;
    logic       ev1, ed1;
    logic       c2, ev2;
    logic [1:0] ed2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic sv, e, r, input logic [3:0] ex, input logic ev1, ed1,
                              input logic c2, ev2, input logic [1:0] ed2);
    vec_t t;
    t.sv = sv; t.en = e; t.rdy = r; t.ex = ex; t.ev1 = ev1; t.ed1 = ed1;
    t.c2 = c2; t.ev2 = ev2; t.ed2 = ed2;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic sv, input logic e, input logic r);
    @(negedge clk);
    seed_valid = sv;
    en         = e;
    dout_ready = r;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] mx;

  initial begin
    // Seed x=1 y=2 p=3 q=4: emitted bits 0@2 1@7 0@8 1@9 1@11 1@12.
    tbl.push_back(mk(1, 0, 1,  1, 0, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  4, 0, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1, 13, 1, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  8, 0, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  9, 0, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1, 12, 0, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  5, 0, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  0, 1, 1, 1, 1, 2'b01));
    tbl.push_back(mk(0, 1, 1,  1, 1, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  4, 1, 1, 1, 1, 2'b01));
    tbl.push_back(mk(0, 1, 1, 13, 0, 1, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  8, 1, 1, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  9, 1, 1, 1, 1, 2'b11));
    tbl.push_back(mk(0, 0, 1,  9, 0, 1, 1, 0, 2'b00));
    // Backpressure on the OUT_W=1 stream; dout is not cleared by a seed.
    tbl.push_back(mk(1, 0, 1,  1, 0, 1, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  4, 0, 1, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1, 13, 1, 0, 1, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0,  8, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0,  9, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0, 12, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0,  5, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0,  5, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0,  5, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 0,  5, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  0, 1, 1, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  1, 1, 0, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1,  4, 1, 1, 0, 0, 2'b00));
    tbl.push_back(mk(0, 1, 1, 13, 0, 1, 0, 0, 2'b00));

    #12;
    check("rst dout_valid", 32'(v1), 32'd0);
    check("rst dout", 32'(dout1), 32'd0);
    check("rst health_fail", 32'(hf1), 32'd0);
    check("rst seed_ready", 32'(sr1), 32'd1);
    check("rst state", 32'(dut1.state), 32'(IDLE));
    check("rst x", 32'(dut1.x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].sv, tbl[i].en, tbl[i].rdy);
      check($sformatf("row%0d x", i), 32'(dut1.x), 32'(tbl[i].ex));
      check($sformatf("row%0d valid1", i), 32'(v1), 32'(tbl[i].ev1));
      check($sformatf("row%0d dout1", i), 32'(dout1), 32'(tbl[i].ed1));
      if (tbl[i].c2) begin
        check($sformatf("row%0d valid2", i), 32'(v2), 32'(tbl[i].ev2));
        if (tbl[i].ev2) check($sformatf("row%0d dout2", i), 32'(dout2), 32'(tbl[i].ed2));
      end
    end
    check("no health_fail", 32'(hf1), 32'd0);

    // Reseed in RUN with a partial OUT_W=2 word pending and en low.
    tick(1, 1, 1);
    tick(0, 1, 1);
    tick(0, 1, 1);
    check("partial cnt", 32'(dut2.cnt), 32'd1);
    tick(1, 0, 1);
    check("reseed x", 32'(dut1.x), 32'd1);
    check("reseed cnt", 32'(dut2.cnt), 32'd0);
    check("reseed valid2", 32'(v2), 32'd0);
    mx = 32'd1;
    for (int k = 1; k <= 7; k++) begin
      tick(0, 1, 1);
      mx = lcg_next_ref(mx, DEF_R1, DEF_B1, TW);
      check($sformatf("reseed step%0d x", k), 32'(dut2.x), mx);
      check($sformatf("reseed step%0d valid2", k), 32'(v2), (k == 7) ? 32'd1 : 32'd0);
    end
    check("reseed word", 32'(dout2), 32'd1);
    check("pre-reset valid1", 32'(v1), 32'd1);

    // Asynchronous reset away from any clock edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst valid1", 32'(v1), 32'd0);
    check("async rst state", 32'(dut1.state), 32'(IDLE));
    check("async rst dout1", 32'(dout1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 1, 1);
    tick(0, 1, 1);
    check("idle x held", 32'(dut1.x), 32'd0);
    check("idle valid1", 32'(v1), 32'd0);

`ifdef DCLCG_HEALTH_EN
    // All-zero seeds emit 0 at step 1 and 0 at step 3: a run of two.
    x0 = '0; y0 = '0; p0 = '0; q0 = '0;
    tick(1, 0, 1);
    tick(0, 1, 1);
    check("hlth s1 x", 32'(dut3.x), 32'd1);
    check("hlth s1 valid", 32'(v3), 32'd1);
    check("hlth s1 fail", 32'(hf3), 32'd0);
    tick(0, 1, 1);
    check("hlth s2 x", 32'(dut3.x), 32'd4);
    tick(0, 1, 1);
    check("hlth s3 x", 32'(dut3.x), 32'd13);
    check("hlth s3 fail", 32'(hf3), 32'd1);
    check("hlth s3 valid", 32'(v3), 32'd0);
    check("hlth s3 state", 32'(dut3.state), 32'(FAIL));
    tick(0, 1, 1);
    tick(0, 1, 1);
    check("hlth frozen x", 32'(dut3.x), 32'd13);
    check("hlth sticky", 32'(hf3), 32'd1);
    tick(1, 0, 1);
    check("hlth reseed fail", 32'(hf3), 32'd0);
    check("hlth reseed state", 32'(dut3.state), 32'(RUN));
    tick(0, 1, 1);
    check("hlth resume x", 32'(dut3.x), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
